counter_access_arbiter: RTL and testbench

//  Shares one up/down Counter (count_value, up, down) between N_REQ requesters.

---
 rtl/counter_access_arbiter_pkg.sv | 13 +
 rtl/counter_access_arbiter_if.sv | 26 ++
 rtl/counter_access_arbiter_rr_pick.sv | 31 +++
 rtl/counter_access_arbiter.sv | 98 +++++++++
 tb/tb_counter_access_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/counter_access_arbiter_pkg.sv
// Shared constants and FSM state type for the counter access arbiter.
package counter_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    REJ   = 2'd2
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_access_arbiter_if.sv
// Requester/counter side bundle of the counter access arbiter.
interface counter_access_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 10
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] dir;
  logic [WIDTH-1:0] count_value;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] reject;
  logic             up;
  logic             down;
  logic             busy;

  modport slave (
    input  req, dir, count_value,
    output grant, reject, up, down, busy
  );

  modport master (
    output req, dir, count_value,
    input  grant, reject, up, down, busy
  );

endinterface

// File: rtl/counter_access_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
module counter_access_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [PTR_W-1:0] win_idx,
  output logic             any
);

  int unsigned idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[PTR_W'(idx)]) begin
        any                 = 1'b1;
        win_idx             = PTR_W'(idx);
        win[PTR_W'(idx)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter granting single up/down ops on a shared counter; refuses ops that would wrap.
module counter_access_arbiter
  import counter_access_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  counter_access_arbiter_if.slave   bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q,  state_d;
  logic [PTR_W-1:0] ptr_q,    ptr_d;
  logic [N_REQ-1:0] grant_q,  grant_d;
  logic [N_REQ-1:0] reject_q, reject_d;
  logic             up_q,     up_d;
  logic             down_q,   down_d;
  logic             busy_q,   busy_d;

  logic [N_REQ-1:0] win;
  logic [PTR_W-1:0] win_idx;
  logic             any;
  logic             win_dir;
  logic             bound_hit;

  counter_access_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  // count_value is fresh whenever we are in ARB, so the bound check is exact
  assign win_dir   = bus.dir[win_idx];
  assign bound_hit = ((win_dir == DIR_UP) && (bus.count_value == WIDTH'(MAX_VAL))) ||
                     ((win_dir == DIR_DN) && (bus.count_value == '0));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = '0;
    reject_d = '0;
    up_d     = 1'b0;
    down_d   = 1'b0;
    unique case (state_q)
      ARB: begin
        if (any) begin
          ptr_d = (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + PTR_W'(1);
          if (bound_hit) begin
            state_d  = REJ;
            reject_d = win;
          end else begin
            state_d = ISSUE;
            grant_d = win;
            up_d    = (win_dir == DIR_UP);
            down_d  = (win_dir == DIR_DN);
          end
        end
      end
      ISSUE:   state_d = ARB;
      REJ:     state_d = ARB;
      default: state_d = ARB;
    endcase
    busy_d = (state_d != ARB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      grant_q  <= '0;
      reject_q <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      reject_q <= reject_d;
      up_q     <= up_d;
      down_q   <= down_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.reject = reject_q;
  assign bus.up     = up_q;
  assign bus.down   = down_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed bench: two arbiters (10-bit and 4-bit) each driving a behavioural counter.
module tb_counter_access_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  counter_access_arbiter_if #(.N_REQ(4), .WIDTH(10)) bus_a ();
  counter_access_arbiter_if #(.N_REQ(4), .WIDTH(4))  bus_b ();

  logic [9:0] cnt_a, ld_val_a;
  logic [3:0] cnt_b, ld_val_b;
  logic       ld_a, ld_b;

  counter_access_arbiter #(.N_REQ(4), .WIDTH(10)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  counter_access_arbiter #(.N_REQ(4), .WIDTH(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural counters with a bench-side load port
  always @(posedge clk) begin
    if (ld_a)            cnt_a <= ld_val_a;
    else if (bus_a.up)   cnt_a <= cnt_a + 10'd1;
    else if (bus_a.down) cnt_a <= cnt_a - 10'd1;
    if (ld_b)            cnt_b <= ld_val_b;
    else if (bus_b.up)   cnt_b <= cnt_b + 4'd1;
    else if (bus_b.down) cnt_b <= cnt_b - 4'd1;
  end

  assign bus_a.count_value = cnt_a;
  assign bus_b.count_value = cnt_b;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot_a", 32'($onehot0(bus_a.grant | bus_a.reject)), 32'd1);
      chk("updown_a", 32'(bus_a.up & bus_a.down), 32'd0);
      chk("upgnt_a",  32'(bus_a.up | bus_a.down), 32'(|bus_a.grant));
      chk("onehot_b", 32'($onehot0(bus_b.grant | bus_b.reject)), 32'd1);
      chk("updown_b", 32'(bus_b.up & bus_b.down), 32'd0);
      chk("upgnt_b",  32'(bus_b.up | bus_b.down), 32'(|bus_b.grant));
    end
  end

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    bus_a.req = 4'b1111; bus_a.dir = 4'b1111;
    bus_b.req = 4'b0000; bus_b.dir = 4'b0000;
    ld_a = 1'b1; ld_val_a = 10'd0;
    ld_b = 1'b1; ld_val_b = 4'd0;

    // 1: reset holds everything quiet, first grant goes to req0
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_grant",  32'(bus_a.grant),  32'd0);
      chk("rst_reject", 32'(bus_a.reject), 32'd0);
      chk("rst_up",     32'(bus_a.up),     32'd0);
      chk("rst_down",   32'(bus_a.down),   32'd0);
      chk("rst_busy",   32'(bus_a.busy),   32'd0);
    end
    ld_a = 1'b0; ld_b = 1'b0;
    rst = 1'b0;
    tick();
    chk("t1_grant", 32'(bus_a.grant), 32'b0001);
    chk("t1_up",    32'(bus_a.up),    32'd1);
    chk("t1_busy",  32'(bus_a.busy),  32'd1);
    bus_a.req = 4'b0000;
    tick();
    chk("t1_cnt",   32'(cnt_a),       32'd1);
    chk("t1_idle",  32'(bus_a.grant), 32'd0);

    // 2: count 5, req1 up then req2 down (ptr now 1)
    ld_a = 1'b1; ld_val_a = 10'd5;
    tick();
    ld_a = 1'b0;
    bus_a.req = 4'b0110; bus_a.dir = 4'b0010;
    tick();
    chk("t2_g1",    32'(bus_a.grant), 32'b0010);
    chk("t2_up",    32'(bus_a.up),    32'd1);
    bus_a.req = 4'b0100;
    tick();
    chk("t2_cnt6",  32'(cnt_a),       32'd6);
    chk("t2_gap",   32'(bus_a.grant), 32'd0);
    tick();
    chk("t2_g2",    32'(bus_a.grant), 32'b0100);
    chk("t2_down",  32'(bus_a.down),  32'd1);
    bus_a.req = 4'b0000;
    tick();
    chk("t2_cnt5",  32'(cnt_a),       32'd5);

    // 3: down at zero is rejected, then up is granted
    ld_a = 1'b1; ld_val_a = 10'd0;
    tick();
    ld_a = 1'b0;
    bus_a.req = 4'b0001; bus_a.dir = 4'b0000;
    tick();
    chk("t3_rej",   32'(bus_a.reject), 32'b0001);
    chk("t3_gnt",   32'(bus_a.grant),  32'd0);
    chk("t3_ud",    32'({bus_a.up, bus_a.down}), 32'd0);
    chk("t3_busy",  32'(bus_a.busy),   32'd1);
    bus_a.req = 4'b0000;
    tick();
    chk("t3_cnt0",  32'(cnt_a),        32'd0);
    chk("t3_rej0",  32'(bus_a.reject), 32'd0);
    chk("t3_idle",  32'(bus_a.busy),   32'd0);
    bus_a.req = 4'b0001; bus_a.dir = 4'b0001;
    tick();
    chk("t3_grant", 32'(bus_a.grant),  32'b0001);
    bus_a.req = 4'b0000;
    tick();
    chk("t3_cnt1",  32'(cnt_a),        32'd1);

    // 4: 4-bit counter at 15: up rejected, down granted
    ld_b = 1'b1; ld_val_b = 4'd15;
    tick();
    ld_b = 1'b0;
    bus_b.req = 4'b0001; bus_b.dir = 4'b0001;
    tick();
    chk("t4_rej",   32'(bus_b.reject), 32'b0001);
    chk("t4_noup",  32'(bus_b.up),     32'd0);
    bus_b.req = 4'b0000;
    tick();
    chk("t4_cnt15", 32'(cnt_b),        32'd15);
    bus_b.req = 4'b0001; bus_b.dir = 4'b0000;
    tick();
    chk("t4_grant", 32'(bus_b.grant),  32'b0001);
    chk("t4_down",  32'(bus_b.down),   32'd1);
    bus_b.req = 4'b0000;
    tick();
    chk("t4_cnt14", 32'(cnt_b),        32'd14);

    // 5: all requesters held, round-robin from ptr 0 after reset
    rst = 1'b1;
    ld_a = 1'b1; ld_val_a = 10'd0;
    tick();
    rst = 1'b0; ld_a = 1'b0;
    bus_a.req = 4'b1111; bus_a.dir = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_grant", 32'(bus_a.grant), 32'(1 << (k % 4)));
      tick();
      chk("t5_cnt",   32'(cnt_a),       32'(k + 1));
    end
    bus_a.req = 4'b0000;
    tick();
    tick();
    chk("t5_final", 32'(cnt_a), 32'd5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
